// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 chain controller: register map, FSM
// encodings and the power-up initialisation word table.
package max7219_pkg;

  localparam logic [3:0] ADDR_NOOP   = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0 = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1 = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2 = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3 = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4 = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5 = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6 = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7 = 4'h8;
  localparam logic [3:0] ADDR_DECODE = 4'h9;
  localparam logic [3:0] ADDR_INTENS = 4'hA;
  localparam logic [3:0] ADDR_SCAN   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDN = 4'hC;
  localparam logic [3:0] ADDR_TEST   = 4'hF;

  localparam logic [2:0] INIT_LAST = 3'd4;

  // Top-level command FSM.
  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_INTENS = 2'd2;
  localparam logic [1:0] ST_FRAME  = 2'd3;

  // Word shifter sub-phases; LOAD_WORD is folded into the IDLE/GAP exits.
  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_LOW   = 3'd1;
  localparam logic [2:0] PH_HIGH  = 3'd2;
  localparam logic [2:0] PH_LATCH = 3'd3;
  localparam logic [2:0] PH_GAP   = 3'd4;

  function automatic logic [15:0] mk_word(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] intens);
    case (idx)
      3'd0:    return mk_word(ADDR_SHUTDN, 8'h01);
      3'd1:    return mk_word(ADDR_DECODE, 8'h00);
      3'd2:    return mk_word(ADDR_SCAN, 8'h07);
      3'd3:    return mk_word(ADDR_INTENS, {4'h0, intens});
      default: return mk_word(ADDR_TEST, 8'h00);
    endcase
  endfunction

endpackage

// File: rtl/max7219_word_shifter.sv
// Serialises one 16*N_DEV-bit chain word on SRCLK/SER and strobes RCLK.
// A new word may be started on the last gap cycle so words run back to back.
module max7219_word_shifter
  import max7219_pkg::*;
#(
  parameter int N_DEV   = 4,
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [16*N_DEV-1:0]  word,
  output logic                 ready,
  output logic                 done,
  output logic                 srclk,
  output logic                 rclk,
  output logic                 ser
);

  localparam int NB    = 16 * N_DEV;
  localparam int BIT_W = $clog2(NB);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(NB - 1);

  logic [2:0]       phase, phase_d;
  logic [DIV_W-1:0] div_cnt, div_d;
  logic [BIT_W-1:0] bit_cnt, bit_d;
  logic [NB-1:0]    shreg, sh_d;
  logic             div_last;

  assign div_last = (div_cnt == DIV_MAX);
  assign done     = (phase == PH_GAP) && div_last;
  assign ready    = (phase == PH_IDLE) || done;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    phase_d = phase;
    div_d   = div_last ? '0 : div_cnt + DIV_W'(1);
    bit_d   = bit_cnt;
    sh_d    = shreg;
    case (phase)
      PH_IDLE: begin
        div_d = '0;
        if (start) begin
          phase_d = PH_LOW;
          bit_d   = '0;
          sh_d    = word;
        end
      end
      PH_LOW:  if (div_last) phase_d = PH_HIGH;
      PH_HIGH: begin
        if (div_last) begin
          if (bit_cnt == BIT_MAX) begin
            phase_d = PH_LATCH;
          end else begin
            phase_d = PH_LOW;
            bit_d   = bit_cnt + BIT_W'(1);
            sh_d    = {shreg[NB-2:0], 1'b0};
          end
        end
      end
      PH_LATCH: if (div_last) phase_d = PH_GAP;
      PH_GAP: begin
        if (div_last) begin
          if (start) begin
            phase_d = PH_LOW;
            bit_d   = '0;
            sh_d    = word;
          end else begin
            phase_d = PH_IDLE;
          end
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase   <= PH_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      srclk   <= 1'b0;
      rclk    <= 1'b0;
      ser     <= 1'b0;
    end else begin
      phase   <= phase_d;
      div_cnt <= div_d;
      bit_cnt <= bit_d;
      shreg   <= sh_d;
      // Pins are registered from the next phase so they never glitch.
      srclk   <= (phase_d == PH_HIGH);
      rclk    <= (phase_d == PH_LATCH);
      ser     <= ((phase_d == PH_LOW) || (phase_d == PH_HIGH)) ? sh_d[NB-1] : 1'b0;
    end
  end

endmodule

// File: rtl/max7219_chain_ctrl.sv
// MAX7219 chain controller: runs the init sequence, then sends whole frames
// (one word per row) and pending intensity updates through the word shifter.
module max7219_chain_ctrl
  import max7219_pkg::*;
#(
  parameter int         N_DEV    = 4,
  parameter int         CLK_DIV  = 4,
  parameter logic [3:0] INIT_INT = 4'h8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [64*N_DEV-1:0] frame_data,
  input  logic                frame_valid,
  output logic                frame_ready,
  input  logic [3:0]          intensity_in,
  input  logic                intensity_wr,
  output logic                init_done,
  output logic                busy,
  output logic                SRCLK,
  output logic                RCLK,
  output logic                SER
);

  localparam int NB = 16 * N_DEV;
  localparam int FW = 64 * N_DEV;

  function automatic logic [NB-1:0] bcast(input logic [15:0] w);
    logic [NB-1:0] v;
    for (int d = 0; d < N_DEV; d++) v[d*16 +: 16] = w;
    return v;
  endfunction

  // Device 0 occupies the LSBs so it is shifted last and lands nearest the source.
  function automatic logic [NB-1:0] row_word(input logic [FW-1:0] f, input logic [2:0] r);
    logic [NB-1:0] v;
    for (int d = 0; d < N_DEV; d++)
      v[d*16 +: 16] = mk_word({1'b0, r} + 4'd1, f[d*64 + int'(r)*8 +: 8]);
    return v;
  endfunction

  logic [1:0]    state;
  logic [2:0]    idx;
  logic          last_word;
  logic          pend;
  logic [3:0]    pend_val;
  logic [FW-1:0] frame_buf;

  logic          sh_start, sh_ready, sh_done;
  logic [NB-1:0] sh_word;
  logic          intens_launch, frame_accept;

  assign intens_launch = (state == ST_IDLE) && sh_ready && pend;
  assign frame_ready   = (state == ST_IDLE) && sh_ready && !pend;
  assign frame_accept  = frame_ready && frame_valid;
  assign busy          = (state != ST_IDLE);

  always_comb begin
    sh_start = 1'b0;
    sh_word  = bcast(init_word(idx, INIT_INT));
    case (state)
      ST_INIT: sh_start = sh_ready && !last_word;
      ST_IDLE: begin
        if (intens_launch) begin
          sh_start = 1'b1;
          sh_word  = bcast(mk_word(ADDR_INTENS, {4'h0, pend_val}));
        end else if (frame_accept) begin
          // Row 0 goes straight from the input so the transfer starts on accept.
          sh_start = 1'b1;
          sh_word  = row_word(frame_data, 3'd0);
        end
      end
      ST_FRAME: begin
        sh_start = sh_ready && !last_word;
        sh_word  = row_word(frame_buf, idx);
      end
      default: sh_start = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      idx       <= '0;
      last_word <= 1'b0;
      init_done <= 1'b0;
      pend      <= 1'b0;
      pend_val  <= '0;
    end else begin
      // A write in the launch cycle stays pending, so the newest value wins.
      if (intensity_wr) begin
        pend     <= 1'b1;
        pend_val <= intensity_in;
      end else if (intens_launch) begin
        pend <= 1'b0;
      end

      case (state)
        ST_INIT: begin
          if (sh_start) begin
            idx <= idx + 3'd1;
            if (idx == INIT_LAST) last_word <= 1'b1;
          end
          if (sh_done && last_word) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
            last_word <= 1'b0;
            idx       <= '0;
          end
        end
        ST_IDLE: begin
          if (intens_launch) begin
            state <= ST_INTENS;
          end else if (frame_accept) begin
            state     <= ST_FRAME;
            idx       <= 3'd1;
            last_word <= 1'b0;
          end
        end
        ST_INTENS: if (sh_done) state <= ST_IDLE;
        ST_FRAME: begin
          if (sh_start) begin
            idx <= idx + 3'd1;
            if (idx == 3'd7) last_word <= 1'b1;
          end
          if (sh_done && last_word) begin
            state     <= ST_IDLE;
            last_word <= 1'b0;
            idx       <= '0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // NOTE: the frame buffer is pure datapath and is never read before it is
  // written, so it is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (frame_accept) frame_buf <= frame_data;
  end

  max7219_word_shifter #(
    .N_DEV   (N_DEV),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (sh_start),
    .word  (sh_word),
    .ready (sh_ready),
    .done  (sh_done),
    .srclk (SRCLK),
    .rclk  (RCLK),
    .ser   (SER)
  );

endmodule

// File: tb/tb_max7219_chain_ctrl.sv
// Self-checking bench for max7219_chain_ctrl (N_DEV=2, CLK_DIV=2): a pin
// monitor decodes latched words and compares them against a scoreboard queue.
module tb_max7219_chain_ctrl;

  localparam int N_DEV   = 2;
  localparam int CLK_DIV = 2;
  localparam int W       = (32 * N_DEV + 2) * CLK_DIV;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] frame_data;
  logic         frame_valid;
  logic         frame_ready;
  logic [3:0]   intensity_in;
  logic         intensity_wr;
  logic         init_done;
  logic         busy;
  logic         SRCLK, RCLK, SER;

  always #5 clk = ~clk;

  max7219_chain_ctrl #(
    .N_DEV    (N_DEV),
    .CLK_DIV  (CLK_DIV),
    .INIT_INT (4'h8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .intensity_in (intensity_in),
    .intensity_wr (intensity_wr),
    .init_done    (init_done),
    .busy         (busy),
    .SRCLK        (SRCLK),
    .RCLK         (RCLK),
    .SER          (SER)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pin monitor, sampled on the falling clock edge.
  int          cyc = 0;
  int          last_rise = 0;
  int          m_bits = 0;
  logic [31:0] m_sr = '0;
  logic        p_srclk = 1'b0, p_rclk = 1'b0, p_ser = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_bits = 0;
      m_sr   = '0;
    end else begin
      if (SRCLK && !p_srclk) begin
        check("ser_stable", SER, p_ser);
        if (m_bits > 0) check("srclk_period", cyc - last_rise, 2 * CLK_DIV);
        last_rise = cyc;
        m_sr      = {m_sr[30:0], SER};
        m_bits++;
      end
      if (RCLK) check("srclk_low_in_latch", SRCLK, 1'b0);
      if (RCLK && !p_rclk) begin
        check("word_bits", m_bits, 32);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %08h expected none", m_sr);
        end else begin
          check("word", m_sr, sb.pop_front());
        end
        m_bits = 0;
      end
    end
    p_srclk = SRCLK;
    p_rclk  = RCLK;
    p_ser   = SER;
  end

  function automatic logic [31:0] row_exp(input logic [127:0] f, input int r);
    logic [7:0] a;
    a = 8'(r + 1);
    return {a, f[64 + r*8 +: 8], a, f[r*8 +: 8]};
  endfunction

  task automatic push_init();
    sb.push_back(32'h0C010C01);
    sb.push_back(32'h09000900);
    sb.push_back(32'h0B070B07);
    sb.push_back(32'h0A080A08);
    sb.push_back(32'h0F000F00);
  endtask

  task automatic push_frame(input logic [127:0] f);
    for (int r = 0; r < 8; r++) sb.push_back(row_exp(f, r));
  endtask

  task automatic push_intens(input logic [3:0] v);
    sb.push_back({8'h0A, 4'h0, v, 8'h0A, 4'h0, v});
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy || !init_done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", n < budget, 1'b1);
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!frame_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("ready_in_time", n < budget, 1'b1);
  endtask

  task automatic count_ready_low(output int n);
    n = 0;
    while (!frame_ready && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_state();
    check("rst_srclk", SRCLK, 1'b0);
    check("rst_rclk", RCLK, 1'b0);
    check("rst_ser", SER, 1'b0);
    check("rst_frame_ready", frame_ready, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_busy", busy, 1'b1);
  endtask

  task automatic pulse_intens(input logic [3:0] v);
    @(negedge clk);
    intensity_in = v;
    intensity_wr = 1'b1;
    @(negedge clk);
    intensity_wr = 1'b0;
  endtask

  typedef struct {
    logic [127:0] frame;
    logic         wr;
    logic [3:0]   ival;
    logic [31:0]  first;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    logic [127:0] fa, fb;

    vecs[0] = '{frame: {56'h0, 8'hA5, 56'h0, 8'h3C}, wr: 1'b0, ival: 4'h0, first: 32'h01A5013C};
    vecs[1] = '{frame: 128'h0123456789ABCDEF_FEDCBA9876543210, wr: 1'b1, ival: 4'h3, first: 32'h01EF0110};
    vecs[2] = '{frame: {128{1'b1}}, wr: 1'b0, ival: 4'h0, first: 32'h01FF01FF};
    vecs[3] = '{frame: 128'h8040201008040201_0102040810204080, wr: 1'b1, ival: 4'hF, first: 32'h01010180};

    rst_n        = 1'b0;
    frame_data   = '0;
    frame_valid  = 1'b0;
    intensity_in = '0;
    intensity_wr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state();

    // Init sequence and its exact completion time.
    push_init();
    rst_n = 1'b1;
    @(posedge clk);
    repeat (5 * W - 1) @(posedge clk);
    #1 check("init_done_early", init_done, 1'b0);
    @(posedge clk);
    #1 check("init_done_on_time", init_done, 1'b1);
    wait_idle(500);
    check("idle_busy", busy, 1'b0);
    check("idle_ready", frame_ready, 1'b1);

    // Table-driven frames, some with a same-cycle intensity write.
    for (int i = 0; i < 4; i++) begin
      wait_ready(500);
      @(negedge clk);
      frame_data   = vecs[i].frame;
      frame_valid  = 1'b1;
      intensity_in = vecs[i].ival;
      intensity_wr = vecs[i].wr;
      sb.push_back(vecs[i].first);
      for (int r = 1; r < 8; r++) sb.push_back(row_exp(vecs[i].frame, r));
      if (vecs[i].wr) push_intens(vecs[i].ival);
      @(negedge clk);
      frame_valid  = 1'b0;
      intensity_wr = 1'b0;
      frame_data   = ~vecs[i].frame;
      count_ready_low(n);
      check("ready_low_cycles", n, vecs[i].wr ? 9 * W + 1 : 8 * W);
      wait_idle(3000);
    end

    // frame_valid held high while frame_data changes mid-transfer.
    fa = 128'h11223344_55667788_99AABBCC_DDEEFF00;
    fb = 128'hC0FFEE00_BADF00D1_12345678_0F1E2D3C;
    wait_ready(500);
    @(negedge clk);
    frame_data  = fa;
    frame_valid = 1'b1;
    push_frame(fa);
    push_frame(fb);
    @(negedge clk);
    frame_data = fb;
    count_ready_low(n);
    check("held_valid_gap", n, 8 * W);
    @(negedge clk);
    frame_valid = 1'b0;
    wait_idle(3000);

    // Two intensity writes during one frame: only the last is sent.
    wait_ready(500);
    @(negedge clk);
    frame_data  = 128'h00FF00FF_00FF00FF_FF00FF00_FF00FF00;
    frame_valid = 1'b1;
    push_frame(frame_data);
    push_intens(4'hF);
    @(negedge clk);
    frame_valid = 1'b0;
    repeat (200) @(negedge clk);
    pulse_intens(4'h3);
    repeat (300) @(negedge clk);
    pulse_intens(4'hF);
    wait_idle(3000);

    // Reset during bit 20 of a row word, then an intensity write during init.
    wait_ready(500);
    @(negedge clk);
    frame_data  = 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE;
    frame_valid = 1'b1;
    push_frame(frame_data);
    @(negedge clk);
    frame_valid = 1'b0;
    n = 0;
    while (m_bits != 20 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_bit20", n < 2000, 1'b1);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check_reset_state();
    @(negedge clk);
    push_init();
    push_intens(4'h5);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    pulse_intens(4'h5);
    wait_idle(2000);

    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
